dmem_bus_arbiter: RTL

Shares the single-ported data memory between the pipeline MEM stage (CPU port) and a DMA/boot-loader requester (DMA port). One access is granted per clock. The CPU has priority, and a starvation counter guarantees DMA progress. DMA may lock the bus for bursts, but burst length is bounded so the CPU never stalls indefinitely. The block drives a stall to the pipeline's hazard logic whenever the CPU is denied.

---
 rtl/dmem_bus_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dmem_bus_arbiter.sv
// Arbitrates the single-ported data memory between the MEM-stage CPU port and a DMA port.
// CPU has priority; a starvation counter forces DMA grants and bounded locked bursts protect the CPU.
module dmem_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [BW-1:0] BURST_TOP  = BW'(BURST_MAX);

    typedef enum logic [1:0] {
        S_CPU   = 2'b00,
        S_FORCE = 2'b01,
        S_LOCK  = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [BW-1:0]   burst_q, burst_d, burst_inc;
    logic            cpu_grant, dma_grant, lock_ok;

    // Grants are suppressed while reset is high so no memory write can slip out.
    always_comb begin
        cpu_grant = 1'b0;
        dma_grant = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FORCE, S_LOCK: begin
                    dma_grant = dma_req;
                    cpu_grant = cpu_req & ~dma_req;
                end
                default: begin
                    cpu_grant = cpu_req;
                    dma_grant = dma_req & ~cpu_req;
                end
            endcase
        end
    end

    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_grant) begin
            mem_rd    = ~cpu_we;
            mem_wr    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_grant) begin
            mem_rd    = ~dma_we;
            mem_wr    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;
    assign cpu_stall = cpu_req & ~cpu_grant;
    assign dma_ack   = dma_grant;
    assign owner     = state_q;

    // Only locked grants that keep the CPU waiting consume burst budget.
    always_comb begin
        starve_d  = '0;
        burst_inc = burst_q;
        if (dma_req && !dma_grant)
            starve_d = (starve_q == STARVE_TOP) ? starve_q : starve_q + SW'(1);
        if (dma_grant && dma_lock && cpu_req)
            burst_inc = burst_q + BW'(1);
        lock_ok = dma_grant & dma_lock & (burst_inc != BURST_TOP);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CPU: begin
                if (lock_ok)
                    state_d = S_LOCK;
                else if (starve_d == STARVE_TOP)
                    state_d = S_FORCE;
            end
            S_FORCE: state_d = lock_ok ? S_LOCK : S_CPU;
            S_LOCK: begin
                if (!dma_req || !dma_lock || burst_inc == BURST_TOP)
                    state_d = S_CPU;
            end
            default: state_d = S_CPU;
        endcase
        burst_d = (state_d == S_CPU) ? '0 : burst_inc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_CPU;
            starve_q <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            burst_q  <= burst_d;
        end
    end

endmodule
